// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the SRAM macro.
// The slave modport is the arbiter's view; the master modport is the view of
// the environment around it (both requesters plus the SRAM data return).
interface sram_port_arbiter_if #(
    parameter int AW = 10,
    parameter int BW = 32
) ();

    // Requester 0 (core data side)
    logic          M0_REQ;
    logic          M0_WE;
    logic [AW-1:0] M0_ADDR;
    logic [BW-1:0] M0_WDATA;
    logic          M0_LOCK;
    logic          M0_GNT;
    logic          M0_RVALID;
    logic [BW-1:0] M0_RDATA;

    // Requester 1 (loader / debug / DMA)
    logic          M1_REQ;
    logic          M1_WE;
    logic [AW-1:0] M1_ADDR;
    logic [BW-1:0] M1_WDATA;
    logic          M1_LOCK;
    logic          M1_GNT;
    logic          M1_RVALID;
    logic [BW-1:0] M1_RDATA;

    // SRAM macro pins
    logic          CSN;
    logic          WEN;
    logic [AW-1:0] A;
    logic [BW-1:0] DI;
    logic [BW-1:0] DOUT;

    modport slave (
        input  M0_REQ, M0_WE, M0_ADDR, M0_WDATA, M0_LOCK,
        output M0_GNT, M0_RVALID, M0_RDATA,
        input  M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_LOCK,
        output M1_GNT, M1_RVALID, M1_RDATA,
        output CSN, WEN, A, DI,
        input  DOUT
    );

    modport master (
        output M0_REQ, M0_WE, M0_ADDR, M0_WDATA, M0_LOCK,
        input  M0_GNT, M0_RVALID, M0_RDATA,
        output M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_LOCK,
        input  M1_GNT, M1_RVALID, M1_RDATA,
        input  CSN, WEN, A, DI,
        output DOUT
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter/sequencer for a single-port synchronous SRAM.
// Grants at most one access per cycle (round-robin, with a bounded burst lock),
// drives the SRAM pins combinationally from the winner and returns read data
// with a registered valid one cycle after the granted access.
module sram_port_arbiter #(
    parameter int AW       = 10,
    parameter int BW       = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    sram_port_arbiter_if.slave bus
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t   state, state_n;
    logic          owner, owner_n;   // master holding the lock
    logic          last, last_n;     // master granted most recently
    logic [CW-1:0] lcnt, lcnt_n;     // grants taken so far in the current lock
    logic          rv0, rv0_n;
    logic          rv1, rv1_n;

    logic          gnt0, gnt1;
    logic          owner_req;
    logic          lock_hit;         // lock owner is requesting, so it keeps the port
    logic          win_lock;
    logic [CW-1:0] cnt_inc;

    assign owner_req = owner ? bus.M1_REQ : bus.M0_REQ;
    assign lock_hit  = (state == ST_LOCKED) && owner_req;
    assign win_lock  = gnt1 ? bus.M1_LOCK : bus.M0_LOCK;
    assign cnt_inc   = lock_hit ? (lcnt + CW'(1)) : CW'(1);

    // Lock state, round-robin pointer and pending read valids.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (RST) begin
            state <= ST_FREE;
            owner <= 1'b0;
            last  <= 1'b1;
            lcnt  <= '0;
            rv0   <= 1'b0;
            rv1   <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            lcnt  <= lcnt_n;
            rv0   <= rv0_n;
            rv1   <= rv1_n;
        end
    end

    // Grant selection: lock owner first, else the master that did not win last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            if (lock_hit) begin
                gnt0 = !owner;
                gnt1 = owner;
            end else if (bus.M0_REQ && bus.M1_REQ) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = bus.M0_REQ;
                gnt1 = bus.M1_REQ;
            end
        end
    end

    // Next-state: lock entry/continue/exit and read-response scheduling.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        lcnt_n  = lcnt;
        rv0_n   = gnt0 && !bus.M0_WE;
        rv1_n   = gnt1 && !bus.M1_WE;
        if (gnt0 || gnt1) begin
            last_n = gnt1;
            // Hold the lock only while the winner asks for it and the burst
            // has not yet used up its LOCK_MAX grants; a forced release leaves
            // last pointing at the owner so a waiting master wins next.
            if (win_lock && (cnt_inc < CW'(LOCK_MAX))) begin
                state_n = ST_LOCKED;
                owner_n = gnt1;
                lcnt_n  = cnt_inc;
            end else begin
                state_n = ST_FREE;
                lcnt_n  = '0;
            end
        end else begin
            // No grant while locked means the owner dropped REQ: release.
            state_n = ST_FREE;
            lcnt_n  = '0;
        end
    end

    assign bus.M0_GNT    = gnt0;
    assign bus.M1_GNT    = gnt1;
    assign bus.M0_RVALID = rv0;
    assign bus.M1_RVALID = rv1;
    assign bus.M0_RDATA  = bus.DOUT;
    assign bus.M1_RDATA  = bus.DOUT;

    // Idle cycles leave the M0 request on the pins; only CSN qualifies them.
    assign bus.CSN = !(gnt0 || gnt1);
    assign bus.WEN = RST ? 1'b1 : (gnt1 ? !bus.M1_WE : !bus.M0_WE);
    assign bus.A   = gnt1 ? bus.M1_ADDR  : bus.M0_ADDR;
    assign bus.DI  = gnt1 ? bus.M1_WDATA : bus.M0_WDATA;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for the single-port synchronous SRAM (one access per clock, read data one cycle after the access). It sits between the core's data-side master (M0) and a second master (M1, e.g. a loader or debug/DMA port) and the SRAM macro. It grants at most one access per cycle, using round-robin fairness with an optional bounded lock for bursts, and drives CSN/WEN/A/DI. It returns read data to the winning master with a registered valid one cycle later.

## Interface
- AW, 10, SRAM address width
- BW, 32, data width
- LOCK_MAX, 8, max consecutive locked grants to one master (≥1)
- CLK  input  1  clock, all state on rising edge
- RST  input  1  asynchronous reset, active-high
- M0_REQ / M1_REQ  input  1  access request, held until granted
- M0_WE / M1_WE  input  1  1 = write, 0 = read
- M0_ADDR / M1_ADDR  input  AW  word address
- M0_WDATA / M1_WDATA  input  BW  write data
- M0_LOCK / M1_LOCK  input  1  keep grant for the next access (burst)
- M0_GNT / M1_GNT  output  1  access accepted this cycle (combinational)
- M0_RVALID / M1_RVALID  output  1  read data valid this cycle (registered)
- M0_RDATA / M1_RDATA  output  BW  read data, both driven from DOUT
- CSN  output  1  SRAM chip select, active-low
- WEN  output  1  SRAM 1 = read, 0 = write
- A  output  AW  SRAM address
- DI  output  BW  SRAM write data
- DOUT  input  BW  SRAM read data

## Operation
- State: LAST (last granted master, 1 bit), LOCKED (1 bit), OWNER (1 bit), LCNT (counter 0..LOCK_MAX), RV0/RV1 (pending read valid).
- Unlocked arbitration:
  - Only one REQ high: that master is granted.
  - Both REQ high: the master ≠ LAST is granted.
  - No REQ: no grant, CSN=1.
- Locked (LOCKED=1):
  - OWNER is granted whenever OWNER's REQ=1.
  - If OWNER's REQ=0, the lock releases this cycle and arbitration is unlocked.
- Lock entry: granted access with LOCK=1 while unlocked -> LOCKED=1, OWNER=winner, LCNT=1.
- Lock continue: owner granted with LOCK=1 -> LCNT+1.
- Lock exit, at the end of the granting cycle, when any of:
  - owner granted with LOCK=0;
  - owner REQ=0;
  - LCNT reaches LOCK_MAX on a granted access (forced release). After a forced release, LAST=OWNER, so a waiting other master wins next.
- LAST updates to the winner on every grant.
- SRAM drive on grant: CSN=0, WEN=~Mx_WE, A=Mx_ADDR, DI=Mx_WDATA.
- SRAM drive with no grant: CSN=1; A/DI/WEN hold the M0 values (don't-care).
- Read response: granted read sets RVx=1 for the next cycle only. Mx_RVALID=RVx. Mx_RDATA=DOUT. No backpressure on responses; masters must take the data.
- Writes produce no response.
- Simultaneous events:
  - A new grant in the same cycle as a pending RVALID is legal (fully pipelined).
  - At most one of M0_RVALID/M1_RVALID is high in any cycle.

## Timing
- Reset (RST=1, asynchronous):
  - LAST=1, so M0 wins the first contention.
  - LOCKED=0, OWNER=0, LCNT=0, RV0=RV1=0.
  - M0_GNT=M1_GNT=0 and CSN=1 are forced while RST=1.
  - Outputs: GNT 0, RVALID 0, CSN 1, WEN 1, RDATA=DOUT.
- Reset mid-operation: pending RVALID is dropped, the lock is cleared, and the in-flight read is lost.
- Grant latency: 0 cycles. GNT rises in the same cycle as REQ when the master wins. The SRAM samples at the end of that cycle.
- Read latency: RVALID is high exactly 1 cycle after the granted cycle.
  - DOUT is valid the SRAM access delay (2 time units in the model) after that edge.
  - The master samples RDATA at the following rising edge.
- Throughput: one access per cycle total. Alternating contention gives each master 1 of every 2 cycles.
- Maximum wait for a requesting master: LOCK_MAX+1 cycles.

## Test plan
- Single read:
  - Stimulus: SRAM[5]=0xDEADBEEF; M0_REQ, read, addr 5, one cycle.
  - Response: M0_GNT=1 and CSN=0 that cycle; next cycle M0_RVALID=1, M0_RDATA=0xDEADBEEF, M1_RVALID=0.
- Contention:
  - Stimulus: both masters request reads continuously for 6 cycles after reset.
  - Response: grants go M0, M1, M0, M1, M0, M1; each RVALID follows its grant by 1 cycle.
- Locked burst:
  - Stimulus: M1 reads addrs 0..3 with LOCK=1 on the first three and LOCK=0 on the last; M0 requests throughout.
  - Response: M1 is granted 4 consecutive cycles, then M0 is granted.
- Forced release:
  - Stimulus: LOCK_MAX=8; M0 requests continuously with LOCK=1; M1 also requests.
  - Response: M0 is granted 8 cycles, M1 on the 9th, then M0 re-locks.
- Write-then-read:
  - Stimulus: M0 writes 0x12345678 to addr 9; next cycle M1 reads addr 9.
  - Response: M1_RDATA=0x12345678 one cycle after M1_GNT; no RVALID for the write.
- Reset mid-read:
  - Stimulus: assert RST in the cycle after an M0 read grant.
  - Response: M0_RVALID=0 immediately; after release, LOCKED=0 and the first contention goes to M0.
